// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          REG_AW_DEFAULT = 5;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for a 5-stage pipeline
// with a multi-cycle EX multiplier, load-use detection and MEM redirects.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 2,
  parameter int REG_AW   = REG_AW_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_memread,
  input  logic              id_ex_is_mult,
  input  logic              mem_redirect,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              mult_done,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int              MCNT_W      = $clog2(MULT_LAT) + 1;
  localparam int              MCNT_INIT_I = (MULT_LAT > 1) ? (MULT_LAT - 2) : 0;
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MCNT_INIT_I);

  state_e              state_q, state_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                load_use;

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mcnt_d        = mcnt_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mult_done     = 1'b0;

    if (mem_redirect) begin
      // The redirecting branch is older than anything in EX, so a pending multiply is dropped.
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_d       = RUN;
      mcnt_d        = '0;
    end else if (state_q == MUL) begin
      if (mcnt_q != '0) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        mcnt_d        = mcnt_q - 1'b1;
      end else begin
        mult_done = 1'b1;
        state_d   = RUN;
      end
    end else if (id_ex_is_mult && (MULT_LAT > 1)) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
      state_d       = MUL;
      mcnt_d        = MCNT_INIT;
    end else begin
      mult_done = id_ex_is_mult;
      if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      mult_done     = 1'b0;
    end
  end

  // Reset has priority inside the counters, so reset cycles are never counted.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~pc_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mem_redirect),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       memread, is_mult, redirect;

  logic [2:0] pc_en_w, if_id_en_w, id_ex_en_w, ex_mem_en_w, mem_wb_en_w;
  logic [2:0] flush_w, idb_w, exb_w, done_w;
  logic [15:0] sc2, fc2, sc1, fc1;
  logic [3:0]  sc4, fc4;

  int checks = 0;
  int errors = 0;

  // instance 0: MULT_LAT=2/CNT_W=16, 1: MULT_LAT=4/CNT_W=4, 2: MULT_LAT=1/CNT_W=16
  int lat_m  [3] = '{2, 4, 1};
  int cmax_m [3] = '{65535, 15, 65535};
  int age_m  [3] = '{0, 0, 0};
  int s_m    [3] = '{0, 0, 0};
  int f_m    [3] = '{0, 0, 0};

  logic [8:0] obs_vec [3];
  int         obs_s   [3];
  int         obs_f   [3];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULT_LAT(2), .REG_AW(5), .CNT_W(16)) u_dut_l2 (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2), .id_ex_rd(rd),
    .id_ex_memread(memread), .id_ex_is_mult(is_mult), .mem_redirect(redirect),
    .pc_en(pc_en_w[0]), .if_id_en(if_id_en_w[0]), .id_ex_en(id_ex_en_w[0]),
    .ex_mem_en(ex_mem_en_w[0]), .mem_wb_en(mem_wb_en_w[0]), .if_id_flush(flush_w[0]),
    .id_ex_bubble(idb_w[0]), .ex_mem_bubble(exb_w[0]), .mult_done(done_w[0]),
    .stall_cnt(sc2), .flush_cnt(fc2));

  pipeline_hazard_ctrl #(.MULT_LAT(4), .REG_AW(5), .CNT_W(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2), .id_ex_rd(rd),
    .id_ex_memread(memread), .id_ex_is_mult(is_mult), .mem_redirect(redirect),
    .pc_en(pc_en_w[1]), .if_id_en(if_id_en_w[1]), .id_ex_en(id_ex_en_w[1]),
    .ex_mem_en(ex_mem_en_w[1]), .mem_wb_en(mem_wb_en_w[1]), .if_id_flush(flush_w[1]),
    .id_ex_bubble(idb_w[1]), .ex_mem_bubble(exb_w[1]), .mult_done(done_w[1]),
    .stall_cnt(sc4), .flush_cnt(fc4));

  pipeline_hazard_ctrl #(.MULT_LAT(1), .REG_AW(5), .CNT_W(16)) u_dut_l1 (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2), .id_ex_rd(rd),
    .id_ex_memread(memread), .id_ex_is_mult(is_mult), .mem_redirect(redirect),
    .pc_en(pc_en_w[2]), .if_id_en(if_id_en_w[2]), .id_ex_en(id_ex_en_w[2]),
    .ex_mem_en(ex_mem_en_w[2]), .mem_wb_en(mem_wb_en_w[2]), .if_id_flush(flush_w[2]),
    .id_ex_bubble(idb_w[2]), .ex_mem_bubble(exb_w[2]), .mult_done(done_w[2]),
    .stall_cnt(sc1), .flush_cnt(fc1));

  // bit order: pc, if_id, id_ex, ex_mem, mem_wb enables, flush, id_ex/ex_mem bubbles, mult_done
  function automatic logic [8:0] dut_vec(input int k);
    return {pc_en_w[k], if_id_en_w[k], id_ex_en_w[k], ex_mem_en_w[k], mem_wb_en_w[k],
            flush_w[k], idb_w[k], exb_w[k], done_w[k]};
  endfunction

  function automatic int dut_s(input int k);
    case (k)
      0:       return int'(sc2);
      1:       return int'(sc4);
      default: return int'(sc1);
    endcase
  endfunction

  function automatic int dut_f(input int k);
    case (k)
      0:       return int'(fc2);
      1:       return int'(fc4);
      default: return int'(fc1);
    endcase
  endfunction

  // age = number of cycles the current multiply has already spent stalled in EX
  function automatic void ref_model(input int lat, input int age,
                                    output logic [8:0] e, output int age_nx);
    bit lu;
    lu     = memread && (rd != 0) && ((rd == rs1) || (rd == rs2));
    age_nx = age;
    e      = 9'h1F0;
    if (rst) begin
      e      = 9'h000;
      age_nx = 0;
    end else if (redirect) begin
      e      = 9'h1FE;
      age_nx = 0;
    end else if (age > 0) begin
      if (age < lat - 1) begin
        e      = 9'h032;
        age_nx = age + 1;
      end else begin
        e      = 9'h1F1;
        age_nx = 0;
      end
    end else if (is_mult && lat > 1) begin
      e      = 9'h032;
      age_nx = 1;
    end else begin
      if (lu) e = 9'h074;
      if (is_mult) e[0] = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    logic [8:0] e;
    int         anx [3];
    int         snx [3];
    int         fnx [3];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      obs_vec[k] = dut_vec(k);
      obs_s[k]   = dut_s(k);
      obs_f[k]   = dut_f(k);
      ref_model(lat_m[k], age_m[k], e, anx[k]);
      check("model_vec", k, {23'd0, obs_vec[k]}, {23'd0, e});
      check("model_stall_cnt", k, obs_s[k], s_m[k]);
      check("model_flush_cnt", k, obs_f[k], f_m[k]);
      snx[k] = s_m[k];
      fnx[k] = f_m[k];
      if (rst) begin
        snx[k] = 0;
        fnx[k] = 0;
      end else begin
        if (!e[8] && s_m[k] < cmax_m[k]) snx[k] = s_m[k] + 1;
        if (redirect && f_m[k] < cmax_m[k]) fnx[k] = f_m[k] + 1;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      age_m[k] = anx[k];
      s_m[k]   = snx[k];
      f_m[k]   = fnx[k];
    end
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; memread = 1'b0; is_mult = 1'b0; redirect = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset
    step();
    check("rst_vec", 0, {23'd0, obs_vec[0]}, 32'h000);
    set_idle();
    step();
    check("post_rst_vec", 0, {23'd0, obs_vec[0]}, 32'h1F0);
    check("post_rst_stall", 0, obs_s[0], 0);
    check("post_rst_flush", 0, obs_f[0], 0);

    // load-use, then x0 never stalls
    memread = 1'b1; rd = 5'd5; rs2 = 5'd5;
    step();
    check("lu_vec", 0, {23'd0, obs_vec[0]}, 32'h074);
    set_idle();
    step();
    check("lu_stall_cnt", 0, obs_s[0], 1);
    memread = 1'b1;
    step();
    check("x0_no_stall", 0, {23'd0, obs_vec[0]}, 32'h1F0);

    // multiply held two cycles
    set_idle();
    is_mult = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) is_mult = 1'b0;
      step();
      if (c == 0) check("l2_mul_stall", 0, {23'd0, obs_vec[0]}, 32'h032);
      if (c == 1) check("l2_mul_done", 0, {23'd0, obs_vec[0]}, 32'h1F1);
      if (c < 3)  check("l4_mul_stall", 1, {23'd0, obs_vec[1]}, 32'h032);
      if (c == 3) check("l4_mul_done", 1, {23'd0, obs_vec[1]}, 32'h1F1);
      if (c < 2)  check("l1_mul_done", 2, {23'd0, obs_vec[2]}, 32'h1F1);
    end
    check("l2_stall_total", 0, obs_s[0], 2);
    check("l4_stall_total", 1, obs_s[1], 4);

    // redirect aborts an in-flight multiply
    is_mult = 1'b1;
    step();
    is_mult = 1'b0; redirect = 1'b1;
    step();
    check("redir_in_mul", 1, {23'd0, obs_vec[1]}, 32'h1FE);
    redirect = 1'b0;
    step();
    check("redir_back_run", 1, {23'd0, obs_vec[1]}, 32'h1F0);
    check("redir_flush_cnt", 1, obs_f[1], 1);

    // simultaneous events
    is_mult = 1'b1; memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
    step();
    check("mult_over_lu", 0, {23'd0, obs_vec[0]}, 32'h032);
    set_idle();
    repeat (4) step();
    redirect = 1'b1; memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
    step();
    check("redirect_over_lu", 0, {23'd0, obs_vec[0]}, 32'h1FE);
    set_idle();
    step();

    // saturation of the 4-bit counter
    memread = 1'b1; rd = 5'd7; rs1 = 5'd7;
    repeat (20) step();
    set_idle();
    step();
    check("sat_stall_cnt4", 1, obs_s[1], 15);

    // reset in the middle of a multiply
    is_mult = 1'b1;
    step();
    is_mult = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_mid_mul_vec", 1, {23'd0, obs_vec[1]}, 32'h1F0);
    check("rst_mid_mul_stall", 1, obs_s[1], 0);
    check("rst_mid_mul_flush", 1, obs_f[1], 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      is_mult  = ($urandom_range(0, 3) == 0);
      memread  = ($urandom_range(0, 2) == 0);
      rd       = 5'($urandom_range(0, 3));
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage basic pipeline (IF, ID, EX, MEM, WB) that has the 2-cycle multiplier in EX.
- Drives the enable of the PC register and of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives bubble (clear-control) strobes that force NOP control bits into ID/EX and EX/MEM.
- Handles three events: load-use hazards, the multi-cycle multiply occupying EX, and taken branches/jumps resolved in MEM. Keeps saturating stall and flush counters for performance debug.

Parameters:
- MULT_LAT, 2, cycles a multiply occupies EX (≥1; 1 = no stall).
- REG_AW, 5, register-index width.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_id_rs1  in  REG_AW  rs1 of the instruction in ID.
- if_id_rs2  in  REG_AW  rs2 of the instruction in ID.
- id_ex_rd  in  REG_AW  rd of the instruction in EX.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_is_mult  in  1  instruction in EX is a multiply.
- mem_redirect  in  1  MEM-stage branch taken or jump (membranch & zero, or memjump).
- pc_en  out  1  PC register enable.
- if_id_en  out  1  IF/ID enable.
- id_ex_en  out  1  ID/EX enable.
- ex_mem_en  out  1  EX/MEM enable.
- mem_wb_en  out  1  MEM/WB enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  load zero control into ID/EX.
- ex_mem_bubble  out  1  load zero control into EX/MEM.
- mult_done  out  1  multiply result valid this cycle.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  number of redirects.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- rst=1 at a clock edge: state=RUN, mul counter=0, stall_cnt=0, flush_cnt=0.
- While rst=1, all enables, flush/bubble strobes and mult_done are 0.
- FSM states: RUN, MUL. mcnt is the internal down-counter, width clog2(MULT_LAT)+1.
- Outputs are combinational from state, mcnt and the inputs. State, mcnt and the counters are registered.
- Default (no event): all enables=1, all strobes=0.
- Priority: redirect > mult stall > load-use.
- Redirect (mem_redirect=1, any state):
  - if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1, all enables=1.
  - Next state RUN, mcnt=0; this aborts an in-flight multiply, which is younger than the branch.
  - mult_done=0.
- Mult stall entry (RUN, id_ex_is_mult=1, MULT_LAT>1):
  - pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1, ex_mem_en=mem_wb_en=1.
  - Next state MUL, mcnt=MULT_LAT-2.
- MUL with mcnt≠0: same stall outputs; mcnt decrements.
- MUL with mcnt=0: release; all enables=1, mult_done=1, next state RUN.
- Total stall cycles per multiply = MULT_LAT-1.
- In MUL, id_ex_is_mult is ignored (same instruction).
- MULT_LAT=1: the FSM never leaves RUN; mult_done=id_ex_is_mult in RUN.
- Load-use (RUN, no mult stall, no redirect):
  - Condition: id_ex_memread & id_ex_rd≠0 & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2).
  - Outputs: pc_en=if_id_en=0, id_ex_bubble=1, id_ex_en=1.
  - Exactly one cycle: the load moves on, so the condition clears.
  - Register x0 never causes a stall.
- Bubble/flush strobes imply the corresponding enable is 1; the register loads NOP control.
- stall_cnt increments every non-reset cycle with pc_en=0. flush_cnt increments on each mem_redirect cycle. Both saturate at all-ones and never wrap.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN, MUL);
  - NOP instruction constant 32'h0000_0013;
  - REG_AW default.
- One sub-module, sat_counter (CNT_W, sync rst, inc) → instanced twice for stall_cnt and flush_cnt.
- Hazard compare and FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0, no events → cycle 0 after reset: all enables 1, strobes 0, counters 0.
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5 → one cycle with pc_en=if_id_en=0, id_ex_bubble=1; stall_cnt=1. Repeat with rd=0 → no stall.
- Multiply, MULT_LAT=2: id_ex_is_mult=1 held 2 cycles → cycle0: stall plus ex_mem_bubble; cycle1: mult_done=1, enables 1; stall_cnt=1. With MULT_LAT=4 → 3 stall cycles, mult_done on the 4th.
- Redirect during multiply, MULT_LAT=4: mem_redirect=1 on cycle 1 of MUL → all three flush/bubble strobes high, enables 1, state RUN next cycle, no mult_done; flush_cnt=1.
- Simultaneous events: mult entry plus load-use condition in the same cycle → mult stall outputs, id_ex_bubble=0. Redirect plus load-use → redirect outputs only.
- Saturation, CNT_W=4: 20 consecutive stall cycles → stall_cnt stays 15. Asserting rst mid-MUL → next cycle RUN, counters 0.
